// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared display constants and control-bundle types for the VGA output path
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  localparam int R_W   = 3;
  localparam int G_W   = 3;
  localparam int B_W   = 2;
  localparam int RGB_W = R_W + G_W + B_W;

  localparam int PIPE_LAT = 3;

  localparam logic [RGB_W-1:0] BORDER_RGB_DEF = 8'h02;

  typedef struct packed {
    logic videoon;
    logic in_win;
    logic hs;
    logic vs;
  } ctrl_t;

  // Syncs idle high so a reset never looks like a sync pulse downstream.
  localparam ctrl_t CTRL_RESET = '{videoon: 1'b0, in_win: 1'b0, hs: 1'b1, vs: 1'b1};

endpackage

// File: rtl/vga_delay_line.sv
// rtl/vga_delay_line.sv - WIDTH x DEPTH shift register with async reset to RESET_VAL
module vga_delay_line #(
  parameter int              WIDTH     = 4,
  parameter int              DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= RESET_VAL;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/vga_pixel_fetch.sv
// rtl/vga_pixel_fetch.sv - windowed frame-RAM fetch to RGB332 with 3-clock aligned syncs
module vga_pixel_fetch
  import vga_pkg::*;
#(
  parameter int               IMG_W      = 256,
  parameter int               IMG_H      = 256,
  parameter int               X_OFF      = 192,
  parameter int               Y_OFF      = 112,
  parameter int               ADDR_W     = 16,
  parameter int               PIX_W      = 8,
  parameter logic [RGB_W-1:0] BORDER_RGB = BORDER_RGB_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [10:0]       pixel_x,
  input  logic [10:0]       pixel_y,
  input  logic              videoon,
  input  logic              h_synq,
  input  logic              v_synq,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [PIX_W-1:0]  mem_rdata,
  input  logic              thr_en,
  input  logic [7:0]        thr_val,
  output logic [R_W-1:0]    vga_r,
  output logic [G_W-1:0]    vga_g,
  output logic [B_W-1:0]    vga_b,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              frame_start,
  output logic [7:0]        frame_cnt
);

  localparam int          XW   = $clog2(IMG_W);
  localparam logic [10:0] X_LO = 11'(X_OFF);
  localparam logic [10:0] X_HI = 11'(X_OFF + IMG_W - 1);
  localparam logic [10:0] Y_LO = 11'(Y_OFF);
  localparam logic [10:0] Y_HI = 11'(Y_OFF + IMG_H - 1);

  logic              in_win;
  logic [10:0]       row;
  logic [XW-1:0]     col;
  logic [11+XW-1:0]  addr_full;
  ctrl_t             ctrl_in;
  ctrl_t             ctrl_d;
  logic              vs_prev;
  logic              thr_en_s;
  logic [7:0]        thr_val_s;
  logic [7:0]        pix8;
  logic [RGB_W-1:0]  rgb_next;
  logic              vs_fall_out;

  assign in_win = videoon && (pixel_x >= X_LO) && (pixel_x <= X_HI) &&
                  (pixel_y >= Y_LO) && (pixel_y <= Y_HI);

  assign row       = pixel_y - Y_LO;
  assign col       = XW'(pixel_x - X_LO);
  assign addr_full = {row, col};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr  <= '0;
      mem_rd_en <= 1'b0;
    end else if (in_win) begin
      mem_addr  <= ADDR_W'(addr_full);
      mem_rd_en <= 1'b1;
    end else begin
      mem_rd_en <= 1'b0;
    end
  end

  assign ctrl_in = '{videoon: videoon, in_win: in_win, hs: h_synq, vs: v_synq};

  // Two control stages here plus the output register give the full pipeline latency.
  vga_delay_line #(
    .WIDTH     ($bits(ctrl_t)),
    .DEPTH     (PIPE_LAT - 1),
    .RESET_VAL (CTRL_RESET)
  ) u_ctrl_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (ctrl_in),
    .dout  (ctrl_d)
  );

  // Threshold settings are latched at the input vsync edge so a frame never tears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_prev   <= 1'b1;
      thr_en_s  <= 1'b0;
      thr_val_s <= 8'h80;
    end else begin
      vs_prev <= v_synq;
      if (vs_prev && !v_synq) begin
        thr_en_s  <= thr_en;
        thr_val_s <= thr_val;
      end
    end
  end

  if (PIX_W >= 8) begin : g_pix_wide
    assign pix8 = mem_rdata[PIX_W-1 -: 8];
  end else begin : g_pix_narrow
    assign pix8 = {mem_rdata, {(8-PIX_W){1'b0}}};
  end

  always_comb begin
    rgb_next = '0;
    if (!ctrl_d.videoon) begin
      rgb_next = '0;
    end else if (!ctrl_d.in_win) begin
      rgb_next = BORDER_RGB;
    end else if (thr_en_s) begin
      rgb_next = (pix8 >= thr_val_s) ? 8'hFF : 8'h00;
    end else begin
      rgb_next = {mem_rdata[PIX_W-1 -: R_W], mem_rdata[PIX_W-1 -: G_W], mem_rdata[PIX_W-1 -: B_W]};
    end
  end

  assign vs_fall_out = vga_vs && !ctrl_d.vs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      {vga_r, vga_g, vga_b} <= rgb_next;
      vga_hs      <= ctrl_d.hs;
      vga_vs      <= ctrl_d.vs;
      frame_start <= vs_fall_out;
      if (vs_fall_out) frame_cnt <= frame_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// tb/tb_vga_pixel_fetch.sv - directed self-checking bench for vga_pixel_fetch
module tb_vga_pixel_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] pixel_x, pixel_y;
  logic        videoon, h_synq, v_synq;
  logic [15:0] mem_addr;
  logic        mem_rd_en;
  logic [7:0]  mem_rdata = 8'h00;
  logic        thr_en;
  logic [7:0]  thr_val;
  logic [2:0]  vga_r, vga_g;
  logic [1:0]  vga_b;
  logic        vga_hs, vga_vs, frame_start;
  logic [7:0]  frame_cnt;

  logic [7:0]  mem [65536];

  int n_chk = 0;
  int n_pass = 0;
  int fs_hi = 0;
  int mism = 0;
  logic mon_en = 1'b0;
  logic [1:0] hs_hist = 2'b11;
  logic [1:0] vs_hist = 2'b11;

  vga_pixel_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .videoon     (videoon),
    .h_synq      (h_synq),
    .v_synq      (v_synq),
    .mem_addr    (mem_addr),
    .mem_rd_en   (mem_rd_en),
    .mem_rdata   (mem_rdata),
    .thr_en      (thr_en),
    .thr_val     (thr_val),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .vga_hs      (vga_hs),
    .vga_vs      (vga_vs),
    .frame_start (frame_start),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk = ~clk;

  // Synchronous-read frame RAM model.
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance to the next falling edge; track sync history and frame_start cycles.
  task automatic tick();
    @(negedge clk);
    if (mon_en && (vga_hs !== hs_hist[1] || vga_vs !== vs_hist[1])) mism++;
    if (frame_start === 1'b1) fs_hi++;
    hs_hist = {hs_hist[0], h_synq};
    vs_hist = {vs_hist[0], v_synq};
  endtask

  task automatic pix(input int x, input int y, input logic von);
    pixel_x = 11'(x);
    pixel_y = 11'(y);
    videoon = von;
  endtask

  function automatic logic [31:0] rgb();
    return {24'h0, vga_r, vga_g, vga_b};
  endfunction

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0000] = 8'hA0;
    mem[16'h01FF] = 8'h5C;
    mem[16'hFF00] = 8'hE0;
    mem[16'h0203] = 8'h80;
    mem[16'h0204] = 8'h7F;

    rst_n = 1'b0;
    pix(0, 0, 1'b1);
    h_synq = 1'b1;
    v_synq = 1'b1;
    thr_en = 1'b0;
    thr_val = 8'h00;
    tick(); tick();
    check("rst_rgb", rgb(), 32'h00);
    check("rst_hs", {31'h0, vga_hs}, 32'h1);
    check("rst_vs", {31'h0, vga_vs}, 32'h1);
    check("rst_rd_en", {31'h0, mem_rd_en}, 32'h0);
    check("rst_addr", {16'h0, mem_addr}, 32'h0);
    check("rst_fs", {31'h0, frame_start}, 32'h0);
    check("rst_fcnt", {24'h0, frame_cnt}, 32'h0);

    rst_n = 1'b1;
    tick(); tick();
    check("rel_rgb_2clk", rgb(), 32'h00);
    tick();
    check("rel_rgb_3clk", rgb(), 32'h02);

    // First window pixel: address 0, grayscale of 0xA0.
    pix(192, 112, 1'b1);
    tick();
    check("win0_addr", {16'h0, mem_addr}, 32'h0000);
    check("win0_rd_en", {31'h0, mem_rd_en}, 32'h1);
    pix(0, 0, 1'b1);
    tick();
    check("border_rd_en", {31'h0, mem_rd_en}, 32'h0);
    tick();
    check("win0_rgb", rgb(), 32'hB6);

    // Right edge of line 113, just past it, and just before the left edge.
    pix(447, 113, 1'b1);
    tick();
    check("redge_addr", {16'h0, mem_addr}, 32'h01FF);
    check("redge_rd_en", {31'h0, mem_rd_en}, 32'h1);
    pix(448, 113, 1'b1);
    tick();
    check("past_redge_rd_en", {31'h0, mem_rd_en}, 32'h0);
    check("past_redge_addr_hold", {16'h0, mem_addr}, 32'h01FF);
    pix(191, 113, 1'b1);
    tick();
    check("redge_rgb", rgb(), 32'h49);
    check("ledge_rd_en", {31'h0, mem_rd_en}, 32'h0);
    pix(192, 367, 1'b1);
    tick();
    check("past_redge_rgb", rgb(), 32'h02);
    check("bottom_addr", {16'h0, mem_addr}, 32'hFF00);
    pix(192, 368, 1'b1);
    tick();
    check("ledge_rgb", rgb(), 32'h02);
    check("past_bottom_rd_en", {31'h0, mem_rd_en}, 32'h0);
    pix(200, 200, 1'b0);
    tick();
    check("bottom_rgb", rgb(), 32'hFF);
    check("blank_rd_en", {31'h0, mem_rd_en}, 32'h0);
    pix(0, 0, 1'b1);
    tick();
    check("past_bottom_rgb", rgb(), 32'h02);
    tick();
    check("blank_rgb", rgb(), 32'h00);

    // Threshold requested mid-frame: no effect until the next vsync.
    thr_en = 1'b1;
    thr_val = 8'h80;
    pix(195, 114, 1'b1);
    tick(); tick(); tick();
    check("thr_midframe_gray", rgb(), 32'h92);
    pix(0, 0, 1'b0);
    v_synq = 1'b0;
    tick(); tick();
    v_synq = 1'b1;
    tick(); tick(); tick(); tick();
    check("vs1_fs_cycles", fs_hi, 1);
    check("vs1_fcnt", {24'h0, frame_cnt}, 32'h1);
    thr_val = 8'h00;
    pix(195, 114, 1'b1);
    tick();
    pix(196, 114, 1'b1);
    tick();
    pix(0, 0, 1'b1);
    tick();
    check("thr_eq_hi", rgb(), 32'hFF);
    tick();
    check("thr_below_lo", rgb(), 32'h00);

    // Reset in the middle of the window.
    pix(195, 114, 1'b1);
    tick(); tick(); tick();
    check("pre_rst_rgb", rgb(), 32'hFF);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rgb", rgb(), 32'h00);
    check("mid_rst_hs", {31'h0, vga_hs}, 32'h1);
    check("mid_rst_vs", {31'h0, vga_vs}, 32'h1);
    check("mid_rst_fcnt", {24'h0, frame_cnt}, 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    check("post_rst_gray", rgb(), 32'h92);
    tick(); tick();
    check("post_rst_no_fs", fs_hi, 1);
    pix(0, 0, 1'b0);
    v_synq = 1'b0;
    tick(); tick();
    v_synq = 1'b1;
    tick(); tick(); tick(); tick();
    check("post_rst_fs", fs_hi, 2);
    check("post_rst_fcnt", {24'h0, frame_cnt}, 32'h1);

    // Compressed frames: sync alignment, one pulse per frame, counter wrap.
    mon_en = 1'b1;
    for (int f = 0; f < 256; f++) begin
      for (int c = 0; c < 8; c++) begin
        h_synq = (c % 3) != 0;
        v_synq = c >= 2;
        tick();
      end
      if (f == 254) check("fcnt_wrap_0", {24'h0, frame_cnt}, 32'h0);
    end
    h_synq = 1'b1;
    v_synq = 1'b1;
    tick(); tick(); tick(); tick();
    mon_en = 1'b0;
    check("sync_delay_mism", mism, 0);
    check("frames_fs_cycles", fs_hi, 258);
    check("fcnt_after_256", {24'h0, frame_cnt}, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vga_pixel_fetch.md
Name: vga_pixel_fetch

Overview:
- Downstream stage of the VGA timing controller; consumes pixel_x, pixel_y, videoon, h_synq and v_synq.
- Reads a grayscale image from a synchronous-read frame RAM, which holds the Sobel result or the source image.
- Places the image in a fixed window on the 640x480 display and drives RGB332 plus re-aligned sync signals to the connector.
- Has an optional frame-locked threshold, a frame_start pulse and a frame counter.

Parameters:
- IMG_W, 256, image width in pixels; must be a power of two.
- IMG_H, 256, image height in lines.
- X_OFF, 192, first display column of the window.
- Y_OFF, 112, first display line of the window.
- ADDR_W, 16, RAM address width; must be at least log2(IMG_W*IMG_H).
- PIX_W, 8, RAM data width; must be at least 3.
- BORDER_RGB, 8'h02, RGB332 colour shown inside active video but outside the window.

Ports:
- clk  in  1  pixel clock, the same clock as the timing controller.
- rst_n  in  1  asynchronous, active-low reset.
- pixel_x  in  11  current column from the timing controller.
- pixel_y  in  11  current line from the timing controller.
- videoon  in  1  active-video flag.
- h_synq  in  1  horizontal sync, active low.
- v_synq  in  1  vertical sync, active low.
- mem_addr  out  ADDR_W  frame RAM read address.
- mem_rd_en  out  1  frame RAM read enable.
- mem_rdata  in  PIX_W  frame RAM data, valid one clock after the address is registered.
- thr_en  in  1  threshold mode request.
- thr_val  in  8  threshold level request.
- vga_r  out  3  red.
- vga_g  out  3  green.
- vga_b  out  2  blue.
- vga_hs  out  1  delayed h_synq.
- vga_vs  out  1  delayed v_synq.
- frame_start  out  1  one-clock pulse at the start of each frame.
- frame_cnt  out  8  frame counter.

Behaviour:
- Reset values: mem_addr 0, mem_rd_en 0, vga_r/g/b 0, vga_hs 1, vga_vs 1, frame_start 0, frame_cnt 0. Threshold shadow registers reset to thr_en_s 0 and thr_val_s 8'h80. All pipeline registers clear.
- Window test, combinational on the inputs in cycle N:
  - in_win = videoon && X_OFF <= pixel_x <= X_OFF+IMG_W-1 && Y_OFF <= pixel_y <= Y_OFF+IMG_H-1.
  - Comparisons use 11-bit unsigned arithmetic.
- Stage 1, edge ending cycle N:
  - If in_win: mem_addr = {(pixel_y-Y_OFF), (pixel_x-X_OFF)[log2(IMG_W)-1:0]}, truncated or zero-extended to ADDR_W, and mem_rd_en = 1.
  - Otherwise mem_addr holds its value and mem_rd_en = 0.
  - in_win, videoon, h_synq and v_synq are registered alongside.
- Stage 2: the RAM returns data for the stage-1 address; control bits are delayed one more register.
- Stage 3, output register, selected in priority order:
  - Not videoon: RGB = 0.
  - videoon and not in_win: RGB = BORDER_RGB.
  - in_win and thr_en_s = 1: RGB = 8'hFF if mem_rdata[PIX_W-1 -: 8] >= thr_val_s, else 0. If PIX_W < 8, zero-pad on the right.
  - in_win and thr_en_s = 0: vga_r = vga_g = mem_rdata[PIX_W-1 -: 3] and vga_b = mem_rdata[PIX_W-1 -: 2].
- Latency: vga_r/g/b, vga_hs and vga_vs lag their inputs by exactly 3 clocks. Sync and colour stay aligned through a common delay.
- Threshold shadowing:
  - thr_en and thr_val are copied into the shadow registers only on the cycle the input v_synq is first seen low (1->0 transition).
  - Mid-frame changes take effect on the next frame.
- Frame events:
  - On the output-side transition of vga_vs from 1 to 0, frame_start = 1 for exactly one clock and frame_cnt increments.
  - frame_cnt wraps from 255 to 0.
- Boundaries:
  - Column X_OFF+IMG_W-1 is inside the window; column X_OFF+IMG_W is border.
  - The same rule applies to lines.
  - Window edges that coincide with the display edge are legal.
- Reset mid-frame:
  - Outputs return to reset values immediately, asynchronously.
  - After release, outputs are blank or undefined-free within 3 clocks.
  - No frame_start is produced until the next genuine vsync falling edge. The v_synq edge detector's previous-value register resets to 1.
- The RAM has no back-pressure; the block never stalls.

Decomposition:
- Shared package vga_pkg holds:
  - display constants H_ACTIVE 640 and V_ACTIVE 480;
  - RGB332 field widths;
  - PIPE_LAT 3;
  - the default border colour.
- One sub-module, vga_delay_line: a parameterised WIDTH x DEPTH shift register with async active-low reset to a RESET_VAL parameter. It is used for the {videoon, in_win, h_synq, v_synq} delay.

Test Plan:
- Reset then release with x=0, y=0, videoon=1, h/v_synq=1 -> outputs 0, vga_hs/vs=1, and RGB becomes BORDER_RGB (8'h02) on the 3rd clock.
- Drive x=192, y=112 for one cycle -> mem_addr=0 and mem_rd_en=1 next clock. With mem_rdata=8'hA0, RGB = r5 g5 b2 appears 3 clocks after the input.
- Window edge at y=113: x=447 -> mem_addr=0x01FF. x=448 -> mem_rd_en=0 and the output is BORDER_RGB. x=191 -> border.
- thr_en=1, thr_val=8'h80 applied mid-frame -> grayscale output continues. After the next v_synq falling edge, data 8'h80 gives 8'hFF and 8'h7F gives 0.
- Full-frame run with an 800x525 timing model -> vga_hs/vs equal h_synq/v_synq delayed by 3 clocks. frame_start pulses once per frame. frame_cnt reaches 0 again after 256 frames.
- Assert rst_n low mid-window for 2 clocks -> RGB=0 and syncs=1 immediately. No frame_start occurs until the next vsync edge.
